lr_train_ctrl: RTL and testbench

LR_TRAIN_CTRL -- requirements
Module: lr_train_ctrl

---
 rtl/lr_train_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lr_train_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_train_ctrl.sv
// Linear-regression SGD training sequencer: walks data points/epochs, handshakes with the MAC
// datapath and produces the saturated, learning-rate-scaled error. Optional macro: LR_EARLY_STOP_EN.
module lr_train_ctrl #(
  parameter int DW    = 16,
  parameter int IDX_W = 4,
  parameter int EP_W  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_dp,
  input  logic [EP_W-1:0]  num_epochs,
  input  logic [3:0]       lr_shift,
  output logic [IDX_W-1:0] dp_idx,
  output logic             pred_req,
  input  logic             pred_ack,
  input  logic [DW-1:0]    y_cap,
  input  logic [DW-1:0]    y_in,
  output logic             upd_req,
  input  logic             upd_ack,
  output logic [DW-1:0]    err,
`ifdef LR_EARLY_STOP_EN
  input  logic [DW-1:0]    tol,
  output logic             converged,
`endif
  output logic             busy,
  output logic             done,
  output logic [EP_W-1:0]  epoch
);

  typedef enum logic [2:0] {IDLE, PRED, ERR, UPD, NEXT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  dp_idx_reg, dp_idx_next;
  logic [EP_W-1:0]   epoch_reg, epoch_next;
  logic [IDX_W-1:0]  num_dp_reg, num_dp_next;
  logic [EP_W-1:0]   num_epochs_reg, num_epochs_next;
  logic [3:0]        lr_shift_reg, lr_shift_next;
  logic [DW-1:0]     y_in_reg, y_in_next;
  logic [DW-1:0]     y_cap_reg, y_cap_next;
  logic [DW-1:0]     err_reg, err_next;
  logic              pred_req_reg, upd_req_reg, busy_reg, done_reg;

  logic signed [DW:0] diff_s;
  logic signed [DW:0] shift_s;
  logic [DW-1:0]      err_sat;
  logic [EP_W-1:0]    epoch_inc;

`ifdef LR_EARLY_STOP_EN
  logic              converged_reg, converged_next;
  logic              within_reg, within_next;
  logic [DW:0]       diff_abs;
  logic              diff_ok;
`endif

  // Error path: DW+1 bits so the subtraction can never wrap before saturation.
  always_comb begin
    diff_s  = $signed({y_in_reg[DW-1], y_in_reg}) - $signed({y_cap_reg[DW-1], y_cap_reg});
    shift_s = diff_s >>> lr_shift_reg;
    if (shift_s[DW] != shift_s[DW-1]) begin
      err_sat = shift_s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      err_sat = shift_s[DW-1:0];
    end
  end

`ifdef LR_EARLY_STOP_EN
  always_comb begin
    diff_abs = diff_s[DW] ? unsigned'(-diff_s) : unsigned'(diff_s);
    diff_ok  = (diff_abs <= {1'b0, tol});
  end
`endif

  assign epoch_inc = epoch_reg + EP_W'(1);

  always_comb begin
    state_next      = state_reg;
    dp_idx_next     = dp_idx_reg;
    epoch_next      = epoch_reg;
    num_dp_next     = num_dp_reg;
    num_epochs_next = num_epochs_reg;
    lr_shift_next   = lr_shift_reg;
    y_in_next       = y_in_reg;
    y_cap_next      = y_cap_reg;
    err_next        = err_reg;
`ifdef LR_EARLY_STOP_EN
    converged_next  = converged_reg;
    within_next     = within_reg;
`endif
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
`ifdef LR_EARLY_STOP_EN
            converged_next = 1'b0;
            within_next    = 1'b1;
`endif
            if (num_dp == '0 || num_epochs == '0) begin
              state_next = DONE;
            end else begin
              num_dp_next     = num_dp;
              num_epochs_next = num_epochs;
              lr_shift_next   = lr_shift;
              dp_idx_next     = '0;
              epoch_next      = '0;
              state_next      = PRED;
            end
          end
        end
        PRED: begin
          if (pred_ack) begin
            y_in_next  = y_in;
            y_cap_next = y_cap;
            state_next = ERR;
          end
        end
        ERR: begin
          err_next = err_sat;
`ifdef LR_EARLY_STOP_EN
          within_next = within_reg & diff_ok;
`endif
          state_next = UPD;
        end
        UPD: begin
          if (upd_ack) begin
            state_next = NEXT;
          end
        end
        NEXT: begin
          if (dp_idx_reg == num_dp_reg - IDX_W'(1)) begin
            dp_idx_next = '0;
            epoch_next  = epoch_inc;
            state_next  = (epoch_inc == num_epochs_reg) ? DONE : PRED;
`ifdef LR_EARLY_STOP_EN
            // A whole epoch inside tolerance ends training early.
            within_next = 1'b1;
            if (within_reg) begin
              converged_next = 1'b1;
              state_next     = DONE;
            end
`endif
          end else begin
            dp_idx_next = dp_idx_reg + IDX_W'(1);
            state_next  = PRED;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      dp_idx_reg     <= '0;
      epoch_reg      <= '0;
      num_dp_reg     <= '0;
      num_epochs_reg <= '0;
      lr_shift_reg   <= '0;
      y_in_reg       <= '0;
      y_cap_reg      <= '0;
      err_reg        <= '0;
      pred_req_reg   <= 1'b0;
      upd_req_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dp_idx_reg     <= dp_idx_next;
      epoch_reg      <= epoch_next;
      num_dp_reg     <= num_dp_next;
      num_epochs_reg <= num_epochs_next;
      lr_shift_reg   <= lr_shift_next;
      y_in_reg       <= y_in_next;
      y_cap_reg      <= y_cap_next;
      err_reg        <= err_next;
      // Status outputs decoded from the next state so they are flops aligned with state_reg.
      pred_req_reg   <= (state_next == PRED);
      upd_req_reg    <= (state_next == UPD);
      busy_reg       <= (state_next == PRED) || (state_next == ERR) ||
                        (state_next == UPD)  || (state_next == NEXT);
      done_reg       <= (state_next == DONE);
    end
  end

`ifdef LR_EARLY_STOP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      converged_reg <= 1'b0;
      within_reg    <= 1'b1;
    end else begin
      converged_reg <= converged_next;
      within_reg    <= within_next;
    end
  end

  assign converged = converged_reg;
`endif

  assign dp_idx   = dp_idx_reg;
  assign epoch    = epoch_reg;
  assign err      = err_reg;
  assign pred_req = pred_req_reg;
  assign upd_req  = upd_req_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_lr_train_ctrl.sv
// Directed self-checking bench for lr_train_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_lr_train_ctrl;
  localparam int DW    = 16;
  localparam int IDX_W = 4;
  localparam int EP_W  = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             start, abort;
  logic [IDX_W-1:0] num_dp;
  logic [EP_W-1:0]  num_epochs;
  logic [3:0]       lr_shift;
  logic [IDX_W-1:0] dp_idx;
  logic             pred_req, pred_ack, upd_req, upd_ack;
  logic [DW-1:0]    y_cap, y_in, err;
  logic             busy, done;
  logic [EP_W-1:0]  epoch;
`ifdef LR_EARLY_STOP_EN
  logic [DW-1:0]    tol;
  logic             converged;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  lr_train_ctrl #(.DW(DW), .IDX_W(IDX_W), .EP_W(EP_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .num_dp(num_dp), .num_epochs(num_epochs), .lr_shift(lr_shift),
    .dp_idx(dp_idx), .pred_req(pred_req), .pred_ack(pred_ack),
    .y_cap(y_cap), .y_in(y_in), .upd_req(upd_req), .upd_ack(upd_ack),
    .err(err),
`ifdef LR_EARLY_STOP_EN
    .tol(tol), .converged(converged),
`endif
    .busy(busy), .done(done), .epoch(epoch)
  );

  task automatic test_reset();
    RST_N = 1'b0; start = 0; abort = 0; pred_ack = 0; upd_ack = 0;
    num_dp = '0; num_epochs = '0; lr_shift = '0; y_in = '0; y_cap = '0;
`ifdef LR_EARLY_STOP_EN
    tol = '0;
`endif
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({pred_req, upd_req, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {pred_req, upd_req, busy, done});
    end
    n_cmp++;
    if (dp_idx !== '0 || epoch !== '0 || err !== '0) begin
      n_fail++; $display("FAIL reset_data: got idx=%h ep=%h err=%h expected all 0", dp_idx, epoch, err);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    $display("reset: ctrl=%b idx=%h ep=%h err=%h", {pred_req, upd_req, busy, done}, dp_idx, epoch, err);
  endtask

  task automatic test_err_calc(input logic [DW-1:0] yi, input logic [DW-1:0] yc,
                               input logic [3:0] sh, input logic [DW-1:0] exp_err);
    num_dp = 1; num_epochs = 1; lr_shift = sh; start = 1;
    @(negedge CLK);
    start = 0; lr_shift = 4'hF;
    n_cmp++;
    if (pred_req !== 1'b1) begin
      n_fail++; $display("FAIL err_pred_req: got %b expected 1", pred_req);
    end
    y_in = yi; y_cap = yc; pred_ack = 1;
    @(negedge CLK);
    pred_ack = 0; y_in = '0; y_cap = '0;
    @(negedge CLK);
    n_cmp++;
    if ({pred_req, upd_req} !== 2'b01) begin
      n_fail++; $display("FAIL err_upd_req: got %b expected 01", {pred_req, upd_req});
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_fail++; $display("FAIL err_value: got %h expected %h", err, exp_err);
    end
    @(negedge CLK);
    n_cmp++;
    if (err !== exp_err || upd_req !== 1'b1) begin
      n_fail++; $display("FAIL err_hold: got err=%h req=%b expected %h 1", err, upd_req, exp_err);
    end
    upd_ack = 1;
    @(negedge CLK);
    upd_ack = 0;
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b1 || epoch !== 8'd1) begin
      n_fail++; $display("FAIL err_done: got done=%b ep=%h expected 1 01", done, epoch);
    end
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL err_done_pulse: got %b expected 0", done);
    end
    $display("err_calc: y_in=%h y_cap=%h sh=%0d err=%h", yi, yc, sh, err);
  endtask

  task automatic test_full_run();
    logic [IDX_W-1:0] exp_seq [8];
    int busy_n = 0, done_n = 0, done_at = 0, pred_n = 0, both_n = 0;
    for (int k = 0; k < 8; k++) exp_seq[k] = IDX_W'(k % 4);
    num_dp = 4; num_epochs = 2; lr_shift = 0;
    y_in = 16'h0100; y_cap = 16'h0080; pred_ack = 1; upd_ack = 1; start = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      start = (i == 10);
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = i; end
      if (pred_req && upd_req) both_n++;
      if (pred_req) begin
        if (pred_n < 8) begin
          n_cmp++;
          if (dp_idx !== exp_seq[pred_n]) begin
            n_fail++; $display("FAIL run_idx[%0d]: got %h expected %h", pred_n, dp_idx, exp_seq[pred_n]);
          end
        end
        pred_n++;
      end
    end
    pred_ack = 0; upd_ack = 0; start = 0;
    n_cmp++;
    if (busy_n != 32) begin n_fail++; $display("FAIL run_busy: got %0d expected 32", busy_n); end
    n_cmp++;
    if (done_n != 1 || done_at != 33) begin
      n_fail++; $display("FAIL run_done: got %0d pulses at %0d expected 1 at 33", done_n, done_at);
    end
    n_cmp++;
    if (pred_n != 8) begin n_fail++; $display("FAIL run_points: got %0d expected 8", pred_n); end
    n_cmp++;
    if (epoch !== 8'd2 || dp_idx !== '0) begin
      n_fail++; $display("FAIL run_final: got ep=%h idx=%h expected 02 0", epoch, dp_idx);
    end
    n_cmp++;
    if (both_n != 0) begin n_fail++; $display("FAIL run_req_overlap: got %0d expected 0", both_n); end
    $display("full_run: busy=%0d done=%0d@%0d points=%0d epoch=%0d", busy_n, done_n, done_at, pred_n, epoch);
  endtask

  task automatic test_zero_count(input logic [IDX_W-1:0] ndp, input logic [EP_W-1:0] nep);
    int pred_n = 0;
    logic [2:0] done_seq;
    num_dp = ndp; num_epochs = nep; start = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      start = 0;
      done_seq[i] = done;
      if (pred_req) pred_n++;
    end
    n_cmp++;
    if (done_seq !== 3'b001) begin
      n_fail++; $display("FAIL zero_done: got %b expected 001 (bit0 = 2nd cycle)", done_seq);
    end
    n_cmp++;
    if (pred_n != 0) begin n_fail++; $display("FAIL zero_pred: got %0d expected 0", pred_n); end
    $display("zero_count: num_dp=%0d num_epochs=%0d done_seq=%b", ndp, nep, done_seq);
  endtask

  task automatic test_abort();
    int done_n = 0;
    logic [DW-1:0] held;
    // Stray acks while idle must not start anything.
    pred_ack = 1; upd_ack = 1;
    @(negedge CLK);
    pred_ack = 0; upd_ack = 0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got busy=%b expected 0", busy); end
    num_dp = 2; num_epochs = 1; lr_shift = 1; y_in = 16'h0300; y_cap = 16'h0100; start = 1;
    @(negedge CLK);
    start = 0; pred_ack = 1;
    @(negedge CLK);
    pred_ack = 0;
    @(negedge CLK);
    held = err;
    n_cmp++;
    if (upd_req !== 1'b1 || held !== 16'h0100) begin
      n_fail++; $display("FAIL abort_pre: got req=%b err=%h expected 1 0100", upd_req, held);
    end
    abort = 1; start = 1; upd_ack = 1;
    @(negedge CLK);
    abort = 0; start = 0; upd_ack = 0;
    n_cmp++;
    if ({pred_req, upd_req, busy, done} !== 4'b0000 || err !== held) begin
      n_fail++; $display("FAIL abort_idle: got ctrl=%b err=%h expected 0000 %h",
                         {pred_req, upd_req, busy, done}, err, held);
    end
    repeat (3) begin
      @(negedge CLK);
      if (done || busy) done_n++;
    end
    n_cmp++;
    if (done_n != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_n); end
    $display("abort: err=%h busy=%b done=%b", err, busy, done);
  endtask

  task automatic test_back_to_back();
    int done_at = 0;
    num_dp = 1; num_epochs = 1; lr_shift = 0; y_in = 16'h0010; y_cap = 16'h0004;
    pred_ack = 1; upd_ack = 1; start = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      start = 0;
      if (done && done_at == 0) done_at = i;
    end
    pred_ack = 0; upd_ack = 0;
    n_cmp++;
    if (done_at != 5) begin n_fail++; $display("FAIL b2b_done: got cycle %0d expected 5", done_at); end
    n_cmp++;
    if (err !== 16'h000C) begin n_fail++; $display("FAIL b2b_err: got %h expected 000c", err); end
    $display("back_to_back: done_at=%0d err=%h", done_at, err);
  endtask

  task automatic test_reset_mid();
    int act_n = 0;
    num_dp = 3; num_epochs = 3; pred_ack = 1; upd_ack = 1; start = 1;
    @(negedge CLK);
    start = 0;
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({pred_req, upd_req, busy, done} !== 4'b0000 || dp_idx !== '0 || epoch !== '0) begin
      n_fail++; $display("FAIL reset_mid: got ctrl=%b idx=%h ep=%h expected 0000 0 00",
                         {pred_req, upd_req, busy, done}, dp_idx, epoch);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (done || busy) act_n++;
    end
    pred_ack = 0; upd_ack = 0;
    n_cmp++;
    if (act_n != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d expected 0", act_n); end
    $display("reset_mid: busy=%b done=%b", busy, done);
  endtask

`ifdef LR_EARLY_STOP_EN
  task automatic test_early_stop();
    int done_at = 0;
    tol = 16'h0100; num_dp = 2; num_epochs = 5; lr_shift = 0;
    y_in = 16'h0180; y_cap = 16'h0100; pred_ack = 1; upd_ack = 1; start = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      start = 0;
      if (done && done_at == 0) done_at = i;
    end
    pred_ack = 0; upd_ack = 0;
    n_cmp++;
    if (done_at != 9 || converged !== 1'b1 || epoch !== 8'd1) begin
      n_fail++; $display("FAIL early_stop: got done@%0d conv=%b ep=%h expected 9 1 01", done_at, converged, epoch);
    end
    tol = '0; num_dp = 1; num_epochs = 1; start = 1;
    @(negedge CLK);
    start = 0;
    n_cmp++;
    if (converged !== 1'b0) begin n_fail++; $display("FAIL early_clear: got %b expected 0", converged); end
    abort = 1;
    @(negedge CLK);
    abort = 0;
    $display("early_stop: done_at=%0d epoch=%0d", done_at, epoch);
  endtask
`endif

  initial begin
    test_reset();
    test_err_calc(16'h0F00, 16'h0500, 4'd7, 16'h0014);
    test_err_calc(16'h7F00, 16'h8100, 4'd0, 16'h7FFF);
    test_err_calc(16'h8100, 16'h7F00, 4'd0, 16'h8000);
    test_err_calc(16'h0100, 16'h0300, 4'd2, 16'hFF80);
    test_full_run();
    test_zero_count(4'd0, 8'd3);
    test_zero_count(4'd2, 8'd0);
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef LR_EARLY_STOP_EN
    test_early_stop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
